// File: rtl/mem_lsu_pkg.sv
// rtl/mem_lsu_pkg.sv - shared funct3 codes, FSM state type and lane helpers for the MEM-stage LSU
package mem_lsu_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } lsu_state_e;

    function automatic logic addr_misaligned(input logic [2:0] funct3, input logic [1:0] addr_lo);
        case (funct3)
            F3_H, F3_HU: addr_misaligned = addr_lo[0];
            F3_W:        addr_misaligned = (addr_lo != 2'b00);
            default:     addr_misaligned = 1'b0;
        endcase
    endfunction

    function automatic logic [3:0] byte_en(input logic [2:0] funct3, input logic [1:0] addr_lo);
        case (funct3)
            F3_B, F3_BU: byte_en = 4'b0001 << addr_lo;
            F3_H, F3_HU: byte_en = 4'b0011 << addr_lo;
            default:     byte_en = 4'b1111;
        endcase
    endfunction

    // Undefined funct3 codes fall back to a full-word result.
    function automatic logic [31:0] load_extend(input logic [2:0] funct3, input logic [1:0] addr_lo,
                                                input logic [31:0] word);
        logic [7:0]  lane_b;
        logic [15:0] lane_h;
        lane_b = word[{addr_lo, 3'b000} +: 8];
        lane_h = word[{addr_lo[1], 4'b0000} +: 16];
        case (funct3)
            F3_B:    load_extend = {{24{lane_b[7]}}, lane_b};
            F3_BU:   load_extend = {24'b0, lane_b};
            F3_H:    load_extend = {{16{lane_h[15]}}, lane_h};
            F3_HU:   load_extend = {16'b0, lane_h};
            default: load_extend = word;
        endcase
    endfunction

endpackage

// File: rtl/mem_stage_lsu_ram.sv
// rtl/mem_stage_lsu_ram.sv - byte-enabled data memory, synchronous write and combinational read
module lsu_data_ram #(
    parameter int XLEN      = 32,
    parameter int MEM_DEPTH = 256,
    parameter int AW        = $clog2(MEM_DEPTH)
) (
    input  logic              clk,
    input  logic              we,
    input  logic [XLEN/8-1:0] be,
    input  logic [AW-1:0]     addr,
    input  logic [XLEN-1:0]   wdata,
    output logic [XLEN-1:0]   rdata
);

    // Contents survive reset on purpose; only the pipeline state is cleared.
    logic [XLEN-1:0] mem [MEM_DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            for (int i = 0; i < XLEN/8; i++) begin
                if (be[i]) begin
                    mem[addr][8*i +: 8] <= wdata[8*i +: 8];
                end
            end
        end
    end

    assign rdata = mem[addr];

endmodule

// File: rtl/mem_stage_lsu.sv
// rtl/mem_stage_lsu.sv - MEM pipeline stage: load/store unit, wait-state FSM and MEM/WB register
module mem_stage_lsu
    import mem_lsu_pkg::*;
#(
    parameter int XLEN      = 32,
    parameter int MEM_DEPTH = 256,
    parameter int MEM_LAT   = 0,
    parameter int CNT_W     = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [XLEN-1:0] read_Address_EXMEM,
    input  logic [XLEN-1:0] write_Data_EXMEM,
    input  logic [2:0]      funct3_EXMEM,
    input  logic [4:0]      rd_EXMEM,
    input  logic [XLEN-1:0] PC_plus4_EXMEM,
    input  logic            memRead_EXMEM,
    input  logic            memWrite_EXMEM,
    input  logic [1:0]      mem2reg_EXMEM,
    input  logic            RegWrite_EXMEM,
    input  logic            flush_MEM,
    output logic            stall_MEM,
    output logic            misalign_err,
    output logic [XLEN-1:0] memData_Out_MEMWB,
    output logic [XLEN-1:0] read_Address_MEMWB,
    output logic [4:0]      rd_MEMWB,
    output logic [XLEN-1:0] PC_plus4_MEMWB,
    output logic [1:0]      mem2reg_MEMWB,
    output logic            RegWrite_MEMWB
);

    localparam int AW = $clog2(MEM_DEPTH);
    localparam logic [CNT_W-1:0] LAT_M1 = (MEM_LAT > 0) ? CNT_W'(MEM_LAT - 1) : '0;

    lsu_state_e      state;
    logic [CNT_W-1:0] cnt;

    logic            mem_op;
    logic            is_load;
    logic            misaligned;
    logic            access;
    logic            complete;
    logic            ram_we;
    logic [3:0]      be;
    logic [XLEN-1:0] wdata_rep;
    logic [XLEN-1:0] ram_rdata;
    logic [AW-1:0]   word_idx;

    // A simultaneous read+write is treated as a store; no load data is returned.
    assign mem_op     = memRead_EXMEM | memWrite_EXMEM;
    assign is_load    = memRead_EXMEM & ~memWrite_EXMEM;
    assign misaligned = mem_op & addr_misaligned(funct3_EXMEM, read_Address_EXMEM[1:0]);
    assign access     = mem_op & ~flush_MEM & ~misaligned;
    assign word_idx   = read_Address_EXMEM[AW+1:2];
    assign be         = byte_en(funct3_EXMEM, read_Address_EXMEM[1:0]);

    always_comb begin
        case (funct3_EXMEM)
            F3_B, F3_BU: wdata_rep = {4{write_Data_EXMEM[7:0]}};
            F3_H, F3_HU: wdata_rep = {2{write_Data_EXMEM[15:0]}};
            default:     wdata_rep = write_Data_EXMEM;
        endcase
    end

    always_comb begin
        stall_MEM = 1'b0;
        complete  = 1'b0;
        if (state == WAIT) begin
            stall_MEM = (cnt != '0);
            complete  = access && (cnt == '0);
        end else if (access) begin
            if (MEM_LAT == 0) begin
                complete = 1'b1;
            end else begin
                stall_MEM = 1'b1;
            end
        end
    end

    // Reset is folded in so an access caught by reset never reaches the array.
    assign ram_we = complete & memWrite_EXMEM & ~rst;

    lsu_data_ram #(
        .XLEN      (XLEN),
        .MEM_DEPTH (MEM_DEPTH)
    ) u_ram (
        .clk   (clk),
        .we    (ram_we),
        .be    (be),
        .addr  (word_idx),
        .wdata (wdata_rep),
        .rdata (ram_rdata)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state              <= IDLE;
            cnt                <= '0;
            misalign_err       <= 1'b0;
            memData_Out_MEMWB  <= '0;
            read_Address_MEMWB <= '0;
            rd_MEMWB           <= '0;
            PC_plus4_MEMWB     <= '0;
            mem2reg_MEMWB      <= '0;
            RegWrite_MEMWB     <= 1'b0;
        end else begin
            if (flush_MEM) begin
                state <= IDLE;
                cnt   <= '0;
            end else if (state == IDLE) begin
                if (access && (MEM_LAT > 0)) begin
                    state <= WAIT;
                    cnt   <= LAT_M1;
                end
            end else if (!access || cnt == '0) begin
                state <= IDLE;
                cnt   <= '0;
            end else begin
                cnt <= cnt - CNT_W'(1);
            end

            misalign_err <= 1'b0;
            if (flush_MEM || stall_MEM || misaligned) begin
                misalign_err       <= misaligned & ~flush_MEM & ~stall_MEM;
                memData_Out_MEMWB  <= '0;
                read_Address_MEMWB <= '0;
                rd_MEMWB           <= '0;
                PC_plus4_MEMWB     <= '0;
                mem2reg_MEMWB      <= '0;
                RegWrite_MEMWB     <= 1'b0;
            end else begin
                memData_Out_MEMWB  <= is_load ? load_extend(funct3_EXMEM, read_Address_EXMEM[1:0], ram_rdata)
                                              : '0;
                read_Address_MEMWB <= read_Address_EXMEM;
                rd_MEMWB           <= rd_EXMEM;
                PC_plus4_MEMWB     <= PC_plus4_EXMEM;
                mem2reg_MEMWB      <= mem2reg_EXMEM;
                RegWrite_MEMWB     <= RegWrite_EXMEM;
            end
        end
    end

endmodule

// File: tb/tb_mem_stage_lsu.sv
// tb/tb_mem_stage_lsu.sv - randomized and directed bench for mem_stage_lsu at latency 0 and 3
module tb_mem_stage_lsu;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [2:0]  f3;
        logic [4:0]  rd;
        logic [31:0] pc4;
        logic        rd_en;
        logic        wr_en;
        logic [1:0]  m2r;
        logic        rw;
    } ins_t;

    typedef struct packed {
        logic [31:0] data;
        logic [31:0] addr;
        logic [4:0]  rd;
        logic [31:0] pc4;
        logic [1:0]  m2r;
        logic        rw;
        logic        merr;
    } wb_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [1:0] rst_v;
    logic [1:0] flush_v;
    ins_t       in0, in1;

    logic        o0_stall, o0_merr, o0_rw, o1_stall, o1_merr, o1_rw;
    logic [31:0] o0_data, o0_addr, o0_pc4, o1_data, o1_addr, o1_pc4;
    logic [4:0]  o0_rd, o1_rd;
    logic [1:0]  o0_m2r, o1_m2r;
    wb_t         obs0, obs1;

    assign obs0 = {o0_data, o0_addr, o0_rd, o0_pc4, o0_m2r, o0_rw, o0_merr};
    assign obs1 = {o1_data, o1_addr, o1_rd, o1_pc4, o1_m2r, o1_rw, o1_merr};

    mem_stage_lsu #(.MEM_LAT(0)) u_lat0 (
        .clk(clk), .rst(rst_v[0]),
        .read_Address_EXMEM(in0.addr), .write_Data_EXMEM(in0.wdata), .funct3_EXMEM(in0.f3),
        .rd_EXMEM(in0.rd), .PC_plus4_EXMEM(in0.pc4), .memRead_EXMEM(in0.rd_en),
        .memWrite_EXMEM(in0.wr_en), .mem2reg_EXMEM(in0.m2r), .RegWrite_EXMEM(in0.rw),
        .flush_MEM(flush_v[0]), .stall_MEM(o0_stall), .misalign_err(o0_merr),
        .memData_Out_MEMWB(o0_data), .read_Address_MEMWB(o0_addr), .rd_MEMWB(o0_rd),
        .PC_plus4_MEMWB(o0_pc4), .mem2reg_MEMWB(o0_m2r), .RegWrite_MEMWB(o0_rw)
    );

    mem_stage_lsu #(.MEM_LAT(3)) u_lat3 (
        .clk(clk), .rst(rst_v[1]),
        .read_Address_EXMEM(in1.addr), .write_Data_EXMEM(in1.wdata), .funct3_EXMEM(in1.f3),
        .rd_EXMEM(in1.rd), .PC_plus4_EXMEM(in1.pc4), .memRead_EXMEM(in1.rd_en),
        .memWrite_EXMEM(in1.wr_en), .mem2reg_EXMEM(in1.m2r), .RegWrite_EXMEM(in1.rw),
        .flush_MEM(flush_v[1]), .stall_MEM(o1_stall), .misalign_err(o1_merr),
        .memData_Out_MEMWB(o1_data), .read_Address_MEMWB(o1_addr), .rd_MEMWB(o1_rd),
        .PC_plus4_MEMWB(o1_pc4), .mem2reg_MEMWB(o1_m2r), .RegWrite_MEMWB(o1_rw)
    );

    int          n_chk = 0;
    int          n_err = 0;
    int          cur;
    int          stall_seen;
    bit          chk_en = 1'b0;
    bit          exp_stall_vld;
    bit          exp_stall;
    wb_t         exp_wb;
    wb_t         o_cur;
    logic        st_cur;
    logic [31:0] mdl [2][256];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
        n_chk++;
        if (act !== want) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, want, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            o_cur  = (cur == 0) ? obs0 : obs1;
            st_cur = (cur == 0) ? o0_stall : o1_stall;
            if (st_cur) stall_seen++;
            if (exp_stall_vld) chk("stall_MEM", 32'(st_cur), 32'(exp_stall));
            chk("memData_Out_MEMWB", o_cur.data, exp_wb.data);
            chk("read_Address_MEMWB", o_cur.addr, exp_wb.addr);
            chk("rd_MEMWB", 32'(o_cur.rd), 32'(exp_wb.rd));
            chk("PC_plus4_MEMWB", o_cur.pc4, exp_wb.pc4);
            chk("mem2reg_MEMWB", 32'(o_cur.m2r), 32'(exp_wb.m2r));
            chk("RegWrite_MEMWB", 32'(o_cur.rw), 32'(exp_wb.rw));
            chk("misalign_err", 32'(o_cur.merr), 32'(exp_wb.merr));
        end
    end

    function automatic wb_t cur_obs();
        return (cur == 0) ? obs0 : obs1;
    endfunction

    task automatic set_in(input int sel, input ins_t v);
        if (sel == 0) in0 = v;
        else          in1 = v;
    endtask

    // Reference: derive latency, writeback fields and memory effect from the architectural rules.
    task automatic issue(input int sel, input ins_t v, input int fc);
        int          lat, ns, sh, nbytes, start;
        bit          mem_op, st, ld, mis;
        logic [7:0]  idx;
        logic [31:0] w, b, h;
        wb_t         fin;
        lat    = (sel == 0) ? 0 : 3;
        mem_op = v.rd_en || v.wr_en;
        st     = v.wr_en;
        ld     = v.rd_en && !v.wr_en;
        mis    = mem_op && (((v.f3 == 3'd1 || v.f3 == 3'd5) && v.addr[0]) ||
                            (v.f3 == 3'd2 && v.addr[1:0] != 2'd0));
        ns     = (mem_op && !mis && lat > 0) ? lat : 0;
        idx    = v.addr[9:2];
        w      = mdl[sel][idx];
        fin    = '0;
        if (mis) begin
            fin.merr = 1'b1;
        end else begin
            fin.addr = v.addr;
            fin.rd   = v.rd;
            fin.pc4  = v.pc4;
            fin.m2r  = v.m2r;
            fin.rw   = v.rw;
            if (ld) begin
                sh = 8 * int'(v.addr[1:0]);
                b  = (w >> sh) & 32'hFF;
                h  = (w >> sh) & 32'hFFFF;
                case (v.f3)
                    3'd0:    fin.data = (b >= 128) ? (b | 32'hFFFFFF00) : b;
                    3'd4:    fin.data = b;
                    3'd1:    fin.data = (h >= 32768) ? (h | 32'hFFFF0000) : h;
                    3'd5:    fin.data = h;
                    default: fin.data = w;
                endcase
            end
        end
        set_in(sel, v);
        for (int c = 0; c <= ns; c++) begin
            flush_v[sel]  = (c == fc);
            exp_stall_vld = (c != fc);
            exp_stall     = (c < ns);
            @(posedge clk); #1;
            if (c == fc) begin
                exp_wb       = '0;
                flush_v[sel] = 1'b0;
                return;
            end
            if (c < ns) begin
                exp_wb = '0;
            end else begin
                exp_wb = fin;
                if (st && !mis) begin
                    nbytes = (v.f3 == 3'd0) ? 1 : (v.f3 == 3'd1) ? 2 : 4;
                    start  = (nbytes == 4) ? 0 : int'(v.addr[1:0]);
                    for (int k = 0; k < nbytes; k++)
                        mdl[sel][idx][8*(start+k) +: 8] = 8'((v.wdata >> (8*k)) & 32'hFF);
                end
            end
        end
    endtask

    function automatic ins_t mk(input bit ld, input bit st, input logic [2:0] f3,
                                input logic [31:0] a, input logic [31:0] wd);
        ins_t v;
        v.addr = a; v.wdata = wd; v.f3 = f3; v.rd = 5'd9; v.pc4 = a + 32'd4096;
        v.rd_en = ld; v.wr_en = st; v.m2r = 2'd1; v.rw = ld;
        return v;
    endfunction

    function automatic ins_t rnd_ins();
        ins_t        v;
        logic [31:0] r;
        int          k;
        logic [2:0]  ld_f3 [5];
        ld_f3   = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
        r       = $urandom();
        k       = $urandom_range(0, 9);
        v.addr  = {r[31:10], 2'b00, r[7:0]};
        v.wdata = $urandom();
        v.rd    = 5'($urandom_range(0, 31));
        v.pc4   = $urandom();
        v.m2r   = 2'($urandom_range(0, 3));
        v.rw    = 1'($urandom_range(0, 1));
        v.rd_en = (k <= 3) || (k == 7);
        v.wr_en = (k >= 4) && (k <= 7);
        if (k <= 3) v.f3 = ld_f3[$urandom_range(0, 4)];
        else if (k <= 7) v.f3 = 3'($urandom_range(0, 2));
        else v.f3 = 3'($urandom_range(0, 7));
        return v;
    endfunction

    task automatic init_mem(input int sel);
        for (int i = 0; i < 64; i++) issue(sel, mk(0, 1, 3'd2, 32'(i * 4), $urandom()), -1);
    endtask

    task automatic rnd_phase(input int sel, input int n);
        for (int i = 0; i < n; i++)
            issue(sel, rnd_ins(), ($urandom_range(0, 15) == 0) ? int'($urandom_range(0, 3)) : -1);
    endtask

    task automatic reset_mid_wait(input ins_t v);
        set_in(1, v);
        exp_stall_vld = 1'b1;
        exp_stall     = 1'b1;
        @(posedge clk); #1;
        rst_v[1]  = 1'b1;
        set_in(1, '0);
        exp_wb    = '0;
        exp_stall = 1'b0;
        @(posedge clk); #1;
        chk("rst_wait_data", obs1.data, 32'h0);
        chk("rst_wait_rw", 32'(obs1.rw), 32'h0);
        chk("rst_wait_rd", 32'(obs1.rd), 32'h0);
        rst_v[1] = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        rst_v = 2'b11; flush_v = 2'b00; in0 = '0; in1 = '0; cur = 0; stall_seen = 0;
        exp_wb = '0; exp_stall_vld = 1'b1; exp_stall = 1'b0;
        chk_en = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_lat3_data", obs1.data, 32'h0);
        chk("reset_lat3_pc4", obs1.pc4, 32'h0);
        chk("reset_lat3_rw", 32'(obs1.rw), 32'h0);
        chk("reset_lat3_merr", 32'(obs1.merr), 32'h0);
        rst_v = 2'b00;

        // Single-cycle memory
        init_mem(0);
        stall_seen = 0;
        issue(0, mk(0, 1, 3'd2, 32'h10, 32'hDEADBEEF), -1);
        issue(0, mk(1, 0, 3'd2, 32'h10, 32'h0), -1);
        chk("lw_deadbeef", cur_obs().data, 32'hDEADBEEF);
        chk("lw_regwrite", 32'(cur_obs().rw), 32'h1);
        issue(0, mk(0, 1, 3'd2, 32'h20, 32'h80FF7F01), -1);
        issue(0, mk(1, 0, 3'd0, 32'h23, 32'h0), -1);
        chk("lb_0x23", cur_obs().data, 32'hFFFFFF80);
        issue(0, mk(1, 0, 3'd4, 32'h23, 32'h0), -1);
        chk("lbu_0x23", cur_obs().data, 32'h00000080);
        issue(0, mk(1, 0, 3'd1, 32'h22, 32'h0), -1);
        chk("lh_0x22", cur_obs().data, 32'hFFFF80FF);
        issue(0, mk(1, 0, 3'd5, 32'h20, 32'h0), -1);
        chk("lhu_0x20", cur_obs().data, 32'h00007F01);
        issue(0, mk(0, 1, 3'd2, 32'h30, 32'h0), -1);
        issue(0, mk(0, 1, 3'd0, 32'h31, 32'h000000AB), -1);
        issue(0, mk(1, 0, 3'd2, 32'h30, 32'h0), -1);
        chk("sb_0x31", cur_obs().data, 32'h0000AB00);
        issue(0, mk(0, 1, 3'd1, 32'h32, 32'h00001234), -1);
        issue(0, mk(1, 0, 3'd2, 32'h30, 32'h0), -1);
        chk("sh_0x32", cur_obs().data, 32'h1234AB00);
        issue(0, mk(0, 1, 3'd2, 32'h40, 32'h55667788), -1);
        issue(0, mk(1, 0, 3'd2, 32'h41, 32'h0), -1);
        chk("misalign_lw_err", 32'(cur_obs().merr), 32'h1);
        chk("misalign_lw_rw", 32'(cur_obs().rw), 32'h0);
        issue(0, mk(0, 1, 3'd1, 32'h43, 32'h0000FFFF), -1);
        issue(0, mk(1, 0, 3'd2, 32'h40, 32'h0), -1);
        chk("misalign_sh_nowrite", cur_obs().data, 32'h55667788);
        rnd_phase(0, 300);
        chk("lat0_no_stall", 32'(stall_seen), 32'h0);

        // Three extra wait cycles
        cur = 1; exp_wb = '0; exp_stall = 1'b0; exp_stall_vld = 1'b1;
        init_mem(1);
        issue(1, mk(0, 1, 3'd2, 32'h50, 32'hCAFEF00D), -1);
        stall_seen = 0;
        issue(1, mk(1, 0, 3'd2, 32'h50, 32'h0), -1);
        chk("lat3_stall_cycles", 32'(stall_seen), 32'd3);
        chk("lat3_lw_data", cur_obs().data, 32'hCAFEF00D);
        chk("lat3_lw_rw", 32'(cur_obs().rw), 32'h1);
        issue(1, mk(0, 1, 3'd2, 32'h60, 32'h11112222), -1);
        issue(1, mk(0, 1, 3'd2, 32'h60, 32'h99999999), 1);
        chk("flush_bubble_rd", 32'(cur_obs().rd), 32'h0);
        chk("flush_bubble_m2r", 32'(cur_obs().m2r), 32'h0);
        issue(1, mk(1, 0, 3'd2, 32'h60, 32'h0), -1);
        chk("flush_nowrite", cur_obs().data, 32'h11112222);
        reset_mid_wait(mk(0, 1, 3'd2, 32'h60, 32'h77777777));
        issue(1, mk(1, 0, 3'd2, 32'h60, 32'h0), -1);
        chk("rst_nowrite", cur_obs().data, 32'h11112222);
        rnd_phase(1, 200);

        chk_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/mem_stage_lsu.md
Name: mem_stage_lsu

Overview:
- Parametrised successor of the pipeline MEM stage. Sits between the EX/MEM and MEM/WB pipeline registers.
- Adds byte/halfword/word loads and stores (RV32 funct3), sign/zero extension, byte-lane write enables and misalignment detection.
- Models a configurable-latency data memory; asserts a stall to the hazard unit while an access is outstanding.
- Owns the MEM/WB register, including bubble insertion on stall or flush.

Parameters:
- XLEN, 32, datapath width in bits; only 32 is supported.
- MEM_DEPTH, 256, data memory depth in XLEN-bit words; must be a power of two.
- MEM_LAT, 0, extra wait cycles per memory access (0 = single-cycle, as in the previous generation).
- CNT_W, 4, wait counter width; must satisfy 2**CNT_W > MEM_LAT.

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-high reset
- read_Address_EXMEM  in  XLEN  ALU result / byte address
- write_Data_EXMEM  in  XLEN  store data, right-aligned
- funct3_EXMEM  in  3  000 B, 001 H, 010 W, 100 BU, 101 HU
- rd_EXMEM  in  5  destination register
- PC_plus4_EXMEM  in  XLEN  link value
- memRead_EXMEM  in  1  load
- memWrite_EXMEM  in  1  store
- mem2reg_EXMEM  in  2  writeback select, passed through
- RegWrite_EXMEM  in  1  register write enable
- flush_MEM  in  1  kill the instruction currently in MEM
- stall_MEM  out  1  combinational; hold PC, IF/ID, ID/EX and EX/MEM
- misalign_err  out  1  registered one-cycle pulse
- memData_Out_MEMWB  out  XLEN  extended load data
- read_Address_MEMWB  out  XLEN
- rd_MEMWB  out  5
- PC_plus4_MEMWB  out  XLEN
- mem2reg_MEMWB  out  2
- RegWrite_MEMWB  out  1

Behaviour:
- Reset (asynchronous, while rst=1):
  - All MEM/WB outputs and misalign_err go to 0.
  - FSM goes to IDLE and the counter to 0.
  - Memory contents are not cleared.
- Access definition: access = (memRead_EXMEM | memWrite_EXMEM) & ~flush_MEM & ~misaligned.
- Misalignment rules:
  - H/HU is misaligned when addr[0]=1.
  - W is misaligned when addr[1:0]!=0.
  - B/BU is never misaligned.
- FSM states: IDLE and WAIT.
  - In IDLE, with access=1 and MEM_LAT>0: go to WAIT, counter=MEM_LAT-1, stall_MEM=1.
  - In WAIT, stall_MEM=1 and the counter decrements each cycle. When the counter is 0, the access completes that cycle, stall_MEM=0, and the FSM returns to IDLE.
  - With MEM_LAT=0 the FSM never leaves IDLE and an access completes in the same cycle.
  - EX/MEM inputs are held stable by upstream while stall_MEM=1; this block does not re-register them.
- Store:
  - Memory is written only on the completion edge.
  - Byte enables: B uses 0001<<addr[1:0]; H uses 0011<<addr[1:0]; W uses 1111.
  - Data is replicated across lanes (B: 4x byte, H: 2x half).
  - Word index = addr[log2(MEM_DEPTH)+1:2]; upper address bits are ignored, so the index wraps.
- Load:
  - Read the word, select the lane by addr[1:0], then sign-extend (B, H) or zero-extend (BU, HU).
  - The result is registered into memData_Out_MEMWB on the completion edge.
- MEM/WB register update, evaluated on each edge in priority order:
  1. flush_MEM=1: load a bubble. RegWrite_MEMWB=0, rd_MEMWB=0, mem2reg_MEMWB=0; the other fields are don't-care and are driven to 0. Any pending WAIT is aborted (FSM to IDLE, no memory write).
  2. stall_MEM=1: load a bubble.
  3. Misaligned load or store: load a bubble, pulse misalign_err, and do not write memory.
  4. Otherwise: capture all fields, as in the previous generation.
- Non-memory instructions:
  - Pass through with 1-cycle latency and never stall.
  - memData_Out_MEMWB = 0 for them.
- memRead_EXMEM=1 together with memWrite_EXMEM=1 is illegal. The store takes priority; no load data is produced.
- Asserting rst mid-WAIT abandons the access; the memory is not written.

Decomposition:
- Package mem_lsu_pkg holds:
  - funct3 constants F3_B, F3_H, F3_W, F3_BU, F3_HU
  - FSM state enum {IDLE, WAIT}
  - helper functions byte_en(funct3, addr[1:0]) and load_extend(funct3, addr[1:0], word)
- One sub-module, lsu_data_ram: MEM_DEPTH x XLEN array, synchronous byte-enabled write, combinational read.

Test Plan:
- MEM_LAT=0, SW 0xDEADBEEF @0x10, then LW @0x10 -> memData_Out_MEMWB=0xDEADBEEF one cycle after the load; stall_MEM never asserted.
- Word @0x20=0x80FF7F01. LB @0x23 -> 0xFFFFFF80; LBU @0x23 -> 0x00000080; LH @0x22 -> 0xFFFF80FF; LHU @0x20 -> 0x00007F01.
- SB 0xAB @0x31 into word 0x00000000 -> word becomes 0x0000AB00; SH 0x1234 @0x32 -> word becomes 0x1234AB00.
- MEM_LAT=3, LW -> stall_MEM high for exactly 3 cycles; RegWrite_MEMWB=0 during the stall, then 1 with the correct data.
- LW @0x41 -> misalign_err pulses 1 cycle, RegWrite_MEMWB=0; SH @0x43 leaves memory unchanged.
- MEM_LAT=3, SW issued then flush_MEM asserted in cycle 2 -> FSM returns to IDLE, memory unchanged, bubble in MEM/WB. Repeat with rst asserted mid-WAIT -> same memory result, all outputs 0.
